scr_stack_ram: RTL and testbench

//  Parametrised scratch RAM with an integrated hardware stack pointer. It is the

---
 rtl/scr_stack_ram.sv | 130 +++++++++++++
 tb/tb_scr_stack_ram.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/scr_stack_ram.sv
// rtl/scr_stack_ram.sv - scratch RAM with integrated downward-growing hardware stack (optional guard: SCR_STK_GUARD_EN)
module scr_stack_ram #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic [ADDR_W-1:0] SCR_ADDR,
    input  logic              SCR_WE,
    input  logic              SP_LD,
    input  logic [ADDR_W-1:0] SP_DATA,
    input  logic              PUSH,
    input  logic              POP,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic [ADDR_W-1:0] SP_OUT,
    output logic              STK_EMPTY,
    output logic              STK_FULL,
    output logic              STK_ERR
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] SP_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    // Power-up contents are zero; reset never touches the array.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] sp_dec;
    logic [ADDR_W-1:0] sp_inc;
    logic              stk_full;
    logic              stk_empty;

    assign sp_dec    = sp_q - SP_ONE;
    assign sp_inc    = sp_q + SP_ONE;
    assign stk_full  = (cnt_q == CNT_FULL);
    assign stk_empty = (cnt_q == '0);

    // Read address: top of stack on POP, next free slot on PUSH, else direct address.
    always_comb begin
        rd_addr = SCR_ADDR;
        if (POP && !PUSH)
            rd_addr = sp_q;
        else if (PUSH && !POP)
            rd_addr = sp_dec;
    end

    assign DATA_OUT = mem[rd_addr];

    // Next-state: SP_LD over stack ops over direct write; reset handled in the flops.
    always_comb begin
        sp_d      = sp_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = SCR_ADDR;
        if (SP_LD) begin
            sp_d  = SP_DATA;
            cnt_d = '0;
        end else if (PUSH && POP) begin
            err_d = 1'b1;
        end else if (PUSH) begin
`ifdef SCR_STK_GUARD_EN
            if (stk_full) begin
                err_d = 1'b1;
            end else begin
                mem_we    = 1'b1;
                mem_waddr = sp_dec;
                sp_d      = sp_dec;
                cnt_d     = cnt_q + CNT_ONE;
            end
`else
            mem_we    = 1'b1;
            mem_waddr = sp_dec;
            sp_d      = sp_dec;
            if (!stk_full)
                cnt_d = cnt_q + CNT_ONE;
`endif
        end else if (POP) begin
`ifdef SCR_STK_GUARD_EN
            if (stk_empty) begin
                err_d = 1'b1;
            end else begin
                sp_d  = sp_inc;
                cnt_d = cnt_q - CNT_ONE;
            end
`else
            sp_d = sp_inc;
            if (!stk_empty)
                cnt_d = cnt_q - CNT_ONE;
`endif
        end else if (SCR_WE) begin
            mem_we    = 1'b1;
            mem_waddr = SCR_ADDR;
        end
    end

    // Stack pointer, occupancy and sticky error registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sp_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Memory write port; a reset cycle suppresses any write.
    always_ff @(posedge CLK) begin
        if (!RST && mem_we)
            mem[mem_waddr] <= DATA_IN;
    end

    assign SP_OUT    = sp_q;
    assign STK_EMPTY = stk_empty;
    assign STK_FULL  = stk_full;
    assign STK_ERR   = err_q;

endmodule

// File: tb/tb_scr_stack_ram.sv
// tb/tb_scr_stack_ram.sv - directed self-checking bench for scr_stack_ram
module tb_scr_stack_ram;

`ifdef SCR_STK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [9:0] DATA_IN;
    logic [7:0] SCR_ADDR;
    logic       SCR_WE;
    logic       SP_LD;
    logic [7:0] SP_DATA;
    logic       PUSH;
    logic       POP;
    logic [9:0] DATA_OUT;
    logic [7:0] SP_OUT;
    logic       STK_EMPTY;
    logic       STK_FULL;
    logic       STK_ERR;

    int n_tests = 0;
    int n_fail  = 0;

    scr_stack_ram #(.DATA_W(10), .ADDR_W(8)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .DATA_IN  (DATA_IN),
        .SCR_ADDR (SCR_ADDR),
        .SCR_WE   (SCR_WE),
        .SP_LD    (SP_LD),
        .SP_DATA  (SP_DATA),
        .PUSH     (PUSH),
        .POP      (POP),
        .DATA_OUT (DATA_OUT),
        .SP_OUT   (SP_OUT),
        .STK_EMPTY(STK_EMPTY),
        .STK_FULL (STK_FULL),
        .STK_ERR  (STK_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        RST = 0; SCR_WE = 0; SP_LD = 0; PUSH = 0; POP = 0;
        DATA_IN = '0; SP_DATA = '0; SCR_ADDR = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic peek(input string tag, input logic [7:0] a, input logic [9:0] exp);
        @(negedge CLK);
        idle();
        SCR_ADDR = a;
        #1;
        check(tag, DATA_OUT, exp);
    endtask

    initial begin
        idle();
        RST = 1;
        tick();
        RST = 0;
        // 1: reset state
        check("rst_sp", SP_OUT, 8'h00);
        check("rst_empty", STK_EMPTY, 1'b1);
        check("rst_full", STK_FULL, 1'b0);
        check("rst_err", STK_ERR, 1'b0);

        // 2: direct write, visible only from next cycle
        @(negedge CLK);
        SCR_WE = 1; SCR_ADDR = 8'd5; DATA_IN = 10'd255;
        #1;
        check("wr_same_cycle", DATA_OUT, 10'd0);
        tick();
        idle();
        SCR_ADDR = 8'd5;
        #1;
        check("wr_read5", DATA_OUT, 10'd255);
        peek("wr_read3", 8'd3, 10'd0);

        // 3: two pushes (second-cycle SCR_WE ignored), then pop
        @(negedge CLK);
        PUSH = 1; DATA_IN = 10'h2A1; SCR_WE = 1; SCR_ADDR = 8'd7;
        #1;
        check("push_rd_sp_m1", DATA_OUT, 10'h000);
        tick();
        DATA_IN = 10'h055;
        tick();
        idle();
        check("push2_sp", SP_OUT, 8'hFE);
        check("push2_empty", STK_EMPTY, 1'b0);
        peek("mem_ff", 8'hFF, 10'h2A1);
        peek("mem_fe", 8'hFE, 10'h055);
        peek("push_ignores_we", 8'd7, 10'h000);
        @(negedge CLK);
        idle();
        POP = 1;
        #1;
        check("pop_data", DATA_OUT, 10'h055);
        tick();
        idle();
        check("pop_sp", SP_OUT, 8'hFF);

        // 4: SP_LD overrides a concurrent PUSH; fill the whole stack
        @(negedge CLK);
        SP_LD = 1; SP_DATA = 8'h80; PUSH = 1; DATA_IN = 10'h3AA;
        tick();
        idle();
        check("spld_sp", SP_OUT, 8'h80);
        check("spld_empty", STK_EMPTY, 1'b1);
        peek("spld_no_write", 8'hFE, 10'h055);
        @(negedge CLK);
        for (int i = 0; i < 256; i++) begin
            PUSH = 1; DATA_IN = 10'(i);
            tick();
        end
        idle();
        check("fill_full", STK_FULL, 1'b1);
        check("fill_sp", SP_OUT, 8'h80);
        check("fill_err", STK_ERR, 1'b0);
        peek("fill_7f", 8'h7F, 10'h000);
        peek("fill_80", 8'h80, 10'h0FF);
        peek("fill_05", 8'h05, 10'h07A);
        @(negedge CLK);
        PUSH = 1; DATA_IN = 10'h3FF;
        tick();
        idle();
        check("ovf_sp", SP_OUT, GUARD ? 8'h80 : 8'h7F);
        check("ovf_err", STK_ERR, GUARD);
        check("ovf_full", STK_FULL, 1'b1);
        peek("ovf_7f", 8'h7F, GUARD ? 10'h000 : 10'h3FF);
        @(negedge CLK);
        idle();
        POP = 1;
        #1;
        check("pop_full_data", DATA_OUT, GUARD ? 10'h0FF : 10'h3FF);
        tick();
        idle();
        check("pop_full_sp", SP_OUT, GUARD ? 8'h81 : 8'h80);
        check("pop_full_flag", STK_FULL, 1'b0);
        check("err_sticky", STK_ERR, GUARD);

        // 5: underflow after reset, then simultaneous PUSH&POP
        RST = 1;
        tick();
        RST = 0;
        @(negedge CLK);
        POP = 1;
        #1;
        check("unf_data", DATA_OUT, 10'h07F);
        tick();
        idle();
        check("unf_err", STK_ERR, GUARD);
        check("unf_sp", SP_OUT, GUARD ? 8'h00 : 8'h01);
        check("unf_empty", STK_EMPTY, 1'b1);
        RST = 1;
        tick();
        RST = 0;
        @(negedge CLK);
        PUSH = 1; POP = 1; DATA_IN = 10'h123; SCR_ADDR = 8'hFF;
        #1;
        check("pp_rd_addr", DATA_OUT, 10'h080);
        tick();
        idle();
        check("pp_err", STK_ERR, 1'b1);
        check("pp_sp", SP_OUT, 8'h00);
        check("pp_empty", STK_EMPTY, 1'b1);
        peek("pp_no_write", 8'hFF, 10'h080);

        // 6: reset dominates PUSH and SCR_WE
        @(negedge CLK);
        RST = 1; PUSH = 1; SCR_WE = 1; SCR_ADDR = 8'd5; DATA_IN = 10'h111;
        tick();
        idle();
        check("rstpush_sp", SP_OUT, 8'h00);
        check("rstpush_empty", STK_EMPTY, 1'b1);
        check("rstpush_err", STK_ERR, 1'b0);
        peek("rstpush_mem_ff", 8'hFF, 10'h080);
        peek("rstpush_mem_05", 8'h05, 10'h07A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
